// File: rtl/row_merge_convert.sv
// Row merge/crop converter: gathers N_GROUP channel-group bursts of one pixel row into a
// buffer, interleaving the groups per pixel, then streams out the cropped column window.
module row_merge_convert #(
   parameter int unsigned TBITS     = 64,
   parameter int unsigned TBYTE     = 8,
   parameter int unsigned COLS      = 256,
   parameter int unsigned CH_GROUP  = 32,
   parameter int unsigned N_GROUP   = 2,
   parameter int unsigned COL_START = 24,
   parameter int unsigned COL_OUT   = 208
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             S_AXIS_MM2S_TVALID,
   output logic             S_AXIS_MM2S_TREADY,
   input  logic [TBITS-1:0] S_AXIS_MM2S_TDATA,
   input  logic [TBYTE-1:0] S_AXIS_MM2S_TKEEP,
   input  logic             S_AXIS_MM2S_TLAST,
   output logic             M_AXIS_S2MM_TVALID,
   input  logic             M_AXIS_S2MM_TREADY,
   output logic [TBITS-1:0] M_AXIS_S2MM_TDATA,
   output logic [TBYTE-1:0] M_AXIS_S2MM_TKEEP,
   output logic             M_AXIS_S2MM_TLAST,
   output logic             err_tlast,
   output logic [15:0]      rows_done
);

   localparam int unsigned WPG       = CH_GROUP * 8 / TBITS;
   localparam int unsigned OUT_WORDS = COL_OUT * N_GROUP * WPG;
   localparam int unsigned DEPTH     = COLS * N_GROUP * WPG;
   localparam int unsigned RD_BASE   = COL_START * N_GROUP * WPG;
   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned WW        = (WPG > 1) ? $clog2(WPG) : 1;
   localparam int unsigned PW        = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned GW        = (N_GROUP > 1) ? $clog2(N_GROUP) : 1;
   localparam int unsigned CW        = $clog2(OUT_WORDS + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

   state_e           state_q, state_d;
   logic             s_ready_q, s_ready_d;
   logic [WW-1:0]    w_q;
   logic [PW-1:0]    p_q;
   logic [GW-1:0]    g_q;
   logic             err_q;
   logic [CW-1:0]    rd_cnt_q;
   logic [TBITS-1:0] mem [DEPTH];
   logic [TBITS-1:0] ram_q;
   logic             ram_v_q, ram_last_q;
   logic             m_valid_q, m_last_q;
   logic [TBITS-1:0] m_data_q;
   logic [15:0]      rows_q;

   logic             s_hs, word_last, group_last, load_done;
   logic             adv_out, rd_en, rd_last, out_done;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic             unused_keep;

   assign unused_keep = ^S_AXIS_MM2S_TKEEP;

   assign s_hs       = S_AXIS_MM2S_TVALID & s_ready_q;
   assign word_last  = (p_q == PW'(COLS - 1)) && (w_q == WW'(WPG - 1));
   assign group_last = (g_q == GW'(N_GROUP - 1));
   assign load_done  = s_hs & word_last & group_last;
   // Groups of one pixel sit next to each other so the output is a plain linear scan.
   assign wr_addr    = AW'((32'(p_q) * N_GROUP + 32'(g_q)) * WPG + 32'(w_q));

   // Two-stage read pipe (RAM register, output register); a read is issued only when
   // the RAM register is free or moving forward this cycle.
   assign adv_out  = ~m_valid_q | M_AXIS_S2MM_TREADY;
   assign rd_en    = (state_q == StEmit) && (rd_cnt_q != CW'(OUT_WORDS)) &&
                     (~ram_v_q | adv_out);
   assign rd_last  = (rd_cnt_q == CW'(OUT_WORDS - 1));
   assign rd_addr  = AW'(RD_BASE + 32'(rd_cnt_q));
   assign out_done = m_valid_q & M_AXIS_S2MM_TREADY & m_last_q;

   // Next-state decode; input ready is registered so it stays low throughout reset.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (load_done) state_d = StEmit;
            else if (s_hs) state_d = StLoad;
         end
         StLoad: if (load_done) state_d = StEmit;
         StEmit: if (out_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      s_ready_d = (state_d != StEmit);
   end

   // State and input-ready registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= StIdle;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= s_ready_d;
      end
   end

   // Word/pixel/group load counters and sticky TLAST framing check.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_q   <= '0;
         p_q   <= '0;
         g_q   <= '0;
         err_q <= 1'b0;
      end else if (s_hs) begin
         if (S_AXIS_MM2S_TLAST != word_last) err_q <= 1'b1;
         if (w_q == WW'(WPG - 1)) begin
            w_q <= '0;
            if (p_q == PW'(COLS - 1)) begin
               p_q <= '0;
               g_q <= group_last ? '0 : g_q + 1'b1;
            end else begin
               p_q <= p_q + 1'b1;
            end
         end else begin
            w_q <= w_q + 1'b1;
         end
      end
   end

   // Row buffer with synchronous read; contents survive reset.
   always_ff @(posedge aclk) begin
      if (s_hs) mem[wr_addr] <= S_AXIS_MM2S_TDATA;
      if (rd_en) ram_q <= mem[rd_addr];
   end

   // Read issue counter, pipeline valids, output register and row counter.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_cnt_q   <= '0;
         ram_v_q    <= 1'b0;
         ram_last_q <= 1'b0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
         rows_q     <= '0;
      end else begin
         if (load_done) rd_cnt_q <= '0;
         else if (rd_en) rd_cnt_q <= rd_cnt_q + 1'b1;

         if (rd_en) begin
            ram_v_q    <= 1'b1;
            ram_last_q <= rd_last;
         end else if (adv_out) begin
            ram_v_q <= 1'b0;
         end

         if (adv_out) begin
            m_valid_q <= ram_v_q;
            m_last_q  <= ram_v_q & ram_last_q;
            if (ram_v_q) m_data_q <= ram_q;
         end

         if (out_done) rows_q <= rows_q + 16'd1;
      end
   end

   assign S_AXIS_MM2S_TREADY = s_ready_q;
   assign M_AXIS_S2MM_TVALID = m_valid_q;
   assign M_AXIS_S2MM_TDATA  = m_data_q;
   assign M_AXIS_S2MM_TLAST  = m_last_q;
   assign M_AXIS_S2MM_TKEEP  = {TBYTE{m_valid_q}};
   assign err_tlast          = err_q;
   assign rows_done          = rows_q;

endmodule

// File: doc/row_merge_convert.md
ROW_MERGE_CONVERT -- requirements
Module: row_merge_convert

Interface
REQ-001 The parameters SHALL be as follows:
- TBITS, default 64: stream data width; each word carries TBITS/8 byte-channels of one pixel.
- TBYTE, default 8: TKEEP width.
- COLS, default 256: pixels per input row.
- CH_GROUP, default 32: channels per input burst, a multiple of TBITS/8.
- N_GROUP, default 2: channel-group bursts merged per row, 1..4.
- COL_START, default 24: first output column.
- COL_OUT, default 208: output columns; COL_START+COL_OUT <= COLS.

REQ-002 The ports SHALL be as follows:
- aclk, in, 1: single clock, rising edge.
- aresetn, in, 1: reset, asynchronous, active-low.
- S_AXIS_MM2S_TVALID, in, 1: input beat valid.
- S_AXIS_MM2S_TREADY, out, 1: input accept.
- S_AXIS_MM2S_TDATA, in, TBITS: input word.
- S_AXIS_MM2S_TKEEP, in, TBYTE: ignored.
- S_AXIS_MM2S_TLAST, in, 1: end of burst; checked only.
- M_AXIS_S2MM_TVALID, out, 1: output beat valid.
- M_AXIS_S2MM_TREADY, in, 1: output accept.
- M_AXIS_S2MM_TDATA, out, TBITS: output word.
- M_AXIS_S2MM_TKEEP, out, TBYTE: all ones while TVALID, else 0.
- M_AXIS_S2MM_TLAST, out, 1: last word of the merged row.
- err_tlast, out, 1: sticky flag for TLAST framing mismatch.
- rows_done, out, 16: count of merged rows fully emitted; wraps at 65535->0.

Function
REQ-003 Derived constants SHALL be WPG=CH_GROUP*8/TBITS (words per pixel per group), IN_WORDS=COLS*WPG (words per burst), and OUT_WORDS=COL_OUT*N_GROUP*WPG; defaults give 4, 1024 and 1664.
REQ-004 A handshake SHALL occur only on a cycle where VALID and READY are both 1 at the rising edge.
REQ-005 The block SHALL have exactly three states: IDLE, LOAD and EMIT.
REQ-006 IDLE SHALL drive S TREADY=1 and SHALL go to LOAD on the first input handshake, storing that beat.
REQ-007 LOAD SHALL drive S TREADY=1 and SHALL store beat w of pixel p of group g at address (p*N_GROUP+g)*WPG+w, where the counters w, p and g advance per handshake in that nesting order.
REQ-008 After the handshake of beat IN_WORDS-1 of group N_GROUP-1, the block SHALL go to EMIT.
REQ-009 Burst framing SHALL be count-based only.
REQ-010 TLAST=1 on any beat other than IN_WORDS-1 of a burst, or TLAST=0 on beat IN_WORDS-1, SHALL set err_tlast; counting SHALL continue unchanged.
REQ-011 EMIT SHALL drive S TREADY=0 and SHALL read addresses COL_START*N_GROUP*WPG through (COL_START+COL_OUT)*N_GROUP*WPG-1 in ascending order, giving per pixel the group-0 words, then group-1 words, and so on.
REQ-012 The buffer SHALL be a synchronous-read RAM of COLS*N_GROUP*WPG words, with one read prefetch register or skid register.
REQ-013 The first M TVALID SHALL assert on the 2nd rising edge after the final input handshake.
REQ-014 With M TREADY held at 1, EMIT SHALL produce one word per cycle with no bubbles.
REQ-015 When M TREADY=0, TDATA, TVALID and TLAST SHALL hold stable, and no word SHALL be dropped or duplicated.
REQ-016 M TLAST SHALL be 1 only on word OUT_WORDS-1.
REQ-017 On the handshake of word OUT_WORDS-1, rows_done SHALL increment, M TVALID SHALL deassert on the next cycle, and the state SHALL return to IDLE, with S TREADY=1 on that same next cycle.
REQ-018 Input beats offered while the block is in EMIT SHALL NOT be accepted and SHALL NOT be lost; they SHALL be taken after the return to IDLE.
REQ-019 Buffer contents outside the cropped window SHALL be written but never output.
REQ-020 err_tlast SHALL clear only on reset.

Reset
REQ-021 While aresetn=0, asynchronously, the block SHALL force: state=IDLE; all counters=0; S TREADY=0; M TVALID=0; M TLAST=0; M TKEEP=0; M TDATA=0; err_tlast=0; rows_done=0.
REQ-022 In the first cycle after aresetn rises, S TREADY SHALL become 1.
REQ-023 Reset asserted during LOAD or EMIT SHALL abandon the row; no partial output SHALL follow, and the next input beat SHALL start group 0, pixel 0.
REQ-024 RAM contents need not be cleared by reset.

Verification
REQ-025 Defaults, with burst0 word i=i and burst1 word i=0x10000+i, each TLAST-correct and M TREADY=1, SHALL yield:
- 1664 outputs;
- output 0 = 96 (pixel 24, group 0, word 0) and output 4 = 0x10060;
- TLAST only on output 1663;
- rows_done=1;
- err_tlast=0.
REQ-026 The REQ-025 stimulus with M TREADY toggled by a random 50% pattern SHALL yield an identical output sequence and exactly one TLAST.
REQ-027 The REQ-025 stimulus with TLAST also set on burst0 beat 500 SHALL set err_tlast=1 and still yield output 0 = 96 with 1664 words.
REQ-028 Reset pulsed at output word 800, then a full fresh row, SHALL yield 1664 correct words, rows_done=1, and no stale words.
REQ-029 Row 2 offered back-to-back with row 1 SHALL see S TREADY=0 throughout EMIT, lose no input beat, and end with rows_done=2.
REQ-030 With N_GROUP=1, COL_START=0 and COL_OUT=COLS, the output SHALL equal the input one-for-one at the REQ-014 rate.
